// File: rtl/seg_scan.sv
// Seven-segment scan driver: multiplexes a DIGITS-wide hex value onto one shared decoder.
// Latency: outputs are registered one cycle behind the scan index; new loads show from the next frame wrap.
// Backpressure: value_ready drops while the one-entry pending buffer is full; it frees up at the next frame wrap.
module seg_scan #(
  parameter int DIGITS          = 8,
  parameter int TICKS_PER_DIGIT = 1000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   value_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  value_valid,
  output logic                  value_ready,
  input  logic                  blank_lz,
  output logic [3:0]            digit_nibble,
  output logic                  digit_dp,
  output logic [DIGITS-1:0]     digit_sel_n,
  output logic                  frame_start
);

  localparam int IW = $clog2(DIGITS);
  localparam int PW = $clog2(TICKS_PER_DIGIT);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICKS_PER_DIGIT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

  // Scan position
  logic [PW-1:0]         pre_q, pre_d;
  logic [IW-1:0]         idx_q, idx_d;
  // Value on display and the one-entry pending buffer behind it
  logic [4*DIGITS-1:0]   disp_q, disp_d;
  logic [DIGITS-1:0]     disp_dp_q, disp_dp_d;
  logic [4*DIGITS-1:0]   pend_q, pend_d;
  logic [DIGITS-1:0]     pend_dp_q, pend_dp_d;
  logic                  pend_full_q, pend_full_d;
  // Registered outputs
  logic [DIGITS-1:0]     sel_n_q, sel_n_d;
  logic [3:0]            nib_q, nib_d;
  logic                  dp_q, dp_d;
  logic                  fs_q, fs_d;

  logic                  tick;
  logic                  wrap;
  logic [3:0]            nibs [DIGITS];
  logic [DIGITS-1:0]     zero_from;
  logic                  blanked;

  assign value_ready  = !pend_full_q;
  assign digit_sel_n  = sel_n_q;
  assign digit_nibble = nib_q;
  assign digit_dp     = dp_q;
  assign frame_start  = fs_q;

  // Prescaler/index advance and the load path; a pending value is promoted only on the frame wrap
  always_comb begin
    pre_d       = pre_q;
    idx_d       = idx_q;
    disp_d      = disp_q;
    disp_dp_d   = disp_dp_q;
    pend_d      = pend_q;
    pend_dp_d   = pend_dp_q;
    pend_full_d = pend_full_q;
    tick        = (pre_q == PRE_LAST);
    wrap        = tick && (idx_q == IDX_LAST);

    if (tick) begin
      pre_d = '0;
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end else begin
      pre_d = pre_q + 1'b1;
    end

    // Promotion needs a full buffer and acceptance needs an empty one, so they never collide
    if (wrap && pend_full_q) begin
      disp_d      = pend_q;
      disp_dp_d   = pend_dp_q;
      pend_full_d = 1'b0;
    end
    if (value_valid && !pend_full_q) begin
      pend_d      = value_in;
      pend_dp_d   = dp_in;
      pend_full_d = 1'b1;
    end
  end

  // Per-digit drive for the current index, including leading-zero blanking
  always_comb begin
    logic acc;
    acc = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      nibs[i] = disp_q[4*i +: 4];
    end
    // zero_from[i]: every nibble from i up to the top digit is zero
    zero_from = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      acc          = acc && (nibs[i] == 4'h0);
      zero_from[i] = acc;
    end
    blanked = blank_lz && (idx_q != '0) && zero_from[idx_q] && !disp_dp_q[idx_q];

    sel_n_d = ~(DIGITS'(1) << idx_q);
    nib_d   = nibs[idx_q];
    dp_d    = disp_dp_q[idx_q];
    if (blanked) begin
      sel_n_d = '1;
      nib_d   = 4'h0;
      dp_d    = 1'b0;
    end
    fs_d = (idx_q == '0) && (pre_q == '0);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q       <= '0;
      idx_q       <= '0;
      disp_q      <= '0;
      disp_dp_q   <= '0;
      pend_q      <= '0;
      pend_dp_q   <= '0;
      pend_full_q <= 1'b0;
      sel_n_q     <= '1;
      nib_q       <= 4'h0;
      dp_q        <= 1'b0;
      fs_q        <= 1'b0;
    end else begin
      pre_q       <= pre_d;
      idx_q       <= idx_d;
      disp_q      <= disp_d;
      disp_dp_q   <= disp_dp_d;
      pend_q      <= pend_d;
      pend_dp_q   <= pend_dp_d;
      pend_full_q <= pend_full_d;
      sel_n_q     <= sel_n_d;
      nib_q       <= nib_d;
      dp_q        <= dp_d;
      fs_q        <= fs_d;
    end
  end

endmodule
